// File: rtl/down_counter_part_rtl.sv
// Loadable down-counter (countdown timer) split into a control FSM and a datapath.
// The FSM sequences load / countdown / terminal count / optional auto-reload.

module down_counter_part_ctrl #(
   parameter int AUTO_RELOAD = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic enable,
   input  logic abort,
   input  logic lv_zero,
   input  logic cnt_one,
   input  logic rl_zero,
   output logic sel_load,
   output logic sel_dec,
   output logic sel_reload,
   output logic busy,
   output logic done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e state_q;
   state_e state_d;
   logic   reload_ok;

   // A zero reload value would re-enter DONE forever, so it parks in IDLE instead.
   assign reload_ok = (AUTO_RELOAD != 0) && !rl_zero;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = lv_zero ? DONE : RUN;
      end else if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: state_d = IDLE;
            RUN: begin
               if (enable && cnt_one) begin
                  state_d = DONE;
               end
            end
            DONE:    state_d = reload_ok ? RUN : IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      sel_load   = load;
      sel_dec    = 1'b0;
      sel_reload = 1'b0;
      if (!load && !abort) begin
         sel_dec    = (state_q == RUN) && enable;
         sel_reload = (state_q == DONE) && reload_ok;
      end
      busy = (state_q == RUN);
      done = (state_q == DONE);
   end

endmodule

module down_counter_part_dp #(
   parameter int size = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            sel_load,
   input  logic            sel_dec,
   input  logic            sel_reload,
   input  logic [size-1:0] load_value,
   output logic [size-1:0] count,
   output logic            lv_zero,
   output logic            cnt_one,
   output logic            rl_zero
);

   localparam logic [size-1:0] ONE  = {{(size-1){1'b0}}, 1'b1};
   localparam logic [size-1:0] ZERO = '0;

   logic [size-1:0] count_q;
   logic [size-1:0] count_d;
   logic [size-1:0] reload_q;
   logic [size-1:0] reload_d;

   always_comb begin
      count_d  = count_q;
      reload_d = reload_q;
      if (sel_load) begin
         count_d  = load_value;
         reload_d = load_value;
      end else if (sel_dec) begin
         count_d = count_q - ONE;
      end else if (sel_reload) begin
         count_d = reload_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q  <= ZERO;
         reload_q <= ZERO;
      end else begin
         count_q  <= count_d;
         reload_q <= reload_d;
      end
   end

   assign count   = count_q;
   assign lv_zero = (load_value == ZERO);
   assign cnt_one = (count_q == ONE);
   assign rl_zero = (reload_q == ZERO);

endmodule

module down_counter_part_rtl #(
   parameter int size        = 4,
   parameter int AUTO_RELOAD = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [size-1:0] load_value,
   input  logic            enable,
   input  logic            abort,
   output logic [size-1:0] count,
   output logic            busy,
   output logic            done
);

   logic sel_load;
   logic sel_dec;
   logic sel_reload;
   logic lv_zero;
   logic cnt_one;
   logic rl_zero;

   down_counter_part_ctrl #(
      .AUTO_RELOAD(AUTO_RELOAD)
   ) u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .enable    (enable),
      .abort     (abort),
      .lv_zero   (lv_zero),
      .cnt_one   (cnt_one),
      .rl_zero   (rl_zero),
      .sel_load  (sel_load),
      .sel_dec   (sel_dec),
      .sel_reload(sel_reload),
      .busy      (busy),
      .done      (done)
   );

   down_counter_part_dp #(
      .size(size)
   ) u_dp (
      .clk       (clk),
      .rst       (rst),
      .sel_load  (sel_load),
      .sel_dec   (sel_dec),
      .sel_reload(sel_reload),
      .load_value(load_value),
      .count     (count),
      .lv_zero   (lv_zero),
      .cnt_one   (cnt_one),
      .rl_zero   (rl_zero)
   );

endmodule
